// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and the 4-bit group generate/propagate helper for the pipelined CLA
package cla_pkg;
    localparam int CLA_GROUP_W = 4;

    // Returns {G*, P*} for one 4-bit group.
    function automatic logic [1:0] group_gp(input logic [3:0] g, input logic [3:0] p);
        return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]), &p};
    endfunction
endpackage

// File: rtl/cla_slice.sv
// cla_slice: combinational lookahead adder over SLICE_W/4 groups, also exposing the carry into its MSB
module cla_slice
    import cla_pkg::*;
#(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] sum,
    output logic               co,
    output logic               c_msb
);
    localparam int NG = SLICE_W / CLA_GROUP_W;

    logic [SLICE_W-1:0] g, p, c;
    logic [NG:0]        gc;
    logic [1:0]         gp;

    assign g = a & b;
    assign p = a ^ b;

    // Group carries come from group G*/P*; bit carries are then resolved inside each group.
    always_comb begin
        gc[0] = ci;
        gp = '0;
        for (int j = 0; j < NG; j++) begin
            gp = group_gp(g[j*CLA_GROUP_W +: CLA_GROUP_W], p[j*CLA_GROUP_W +: CLA_GROUP_W]);
            gc[j+1] = gp[1] | (gp[0] & gc[j]);
        end
        c = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            if (i % CLA_GROUP_W == 0) c[i] = gc[i / CLA_GROUP_W];
            if (i < SLICE_W - 1) c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum   = p ^ c;
    assign co    = gc[NG];
    assign c_msb = c[SLICE_W-1];
endmodule

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: pipelined carry-lookahead adder/subtractor, one slice per stage, valid/ready with global stall
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int SLICE_W = WIDTH / NUM_STAGES;
    localparam int LAST    = NUM_STAGES - 1;

    logic advance, ovf_r;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int RW = WIDTH - k * SLICE_W;
        logic [RW-1:0]            xi, yi;
        logic                     ci, v_in, v, cr, co, cm;
        logic [SLICE_W-1:0]       so;
        logic [(k+1)*SLICE_W-1:0] sn, sa;
        if (k == 0) begin : g_src
            assign xi   = x;
            assign yi   = sub ? ~y : y;
            assign ci   = sub | cin;
            assign v_in = in_valid && in_ready;
            assign sn   = so;
        end else begin : g_src
            assign xi   = g_stage[k-1].g_rem.xr;
            assign yi   = g_stage[k-1].g_rem.yr;
            assign ci   = g_stage[k-1].cr;
            assign v_in = g_stage[k-1].v;
            assign sn   = {so, g_stage[k-1].sa};
        end
        cla_slice #(.SLICE_W(SLICE_W)) u_slice (
            .a    (xi[SLICE_W-1:0]),
            .b    (yi[SLICE_W-1:0]),
            .ci   (ci),
            .sum  (so),
            .co   (co),
            .c_msb(cm)
        );
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                v  <= 1'b0;
                cr <= 1'b0;
                sa <= '0;
            end else if (advance) begin
                v  <= v_in;
                cr <= co;
                sa <= sn;
            end
        // Operand bits still to be summed travel down with the partial result.
        if (k < LAST) begin : g_rem
            logic [RW-SLICE_W-1:0] xr, yr;
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) begin
                    xr <= '0;
                    yr <= '0;
                end else if (advance) begin
                    xr <= xi[RW-1:SLICE_W];
                    yr <= yi[RW-1:SLICE_W];
                end
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ovf_r <= 1'b0;
        else if (advance) ovf_r <= g_stage[LAST].cm ^ g_stage[LAST].co;

    assign out_valid = g_stage[LAST].v;
    assign s         = g_stage[LAST].sa;
    assign cout      = g_stage[LAST].cr;
    assign ovf       = ovf_r;
endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: checks the pipelined CLA against an arithmetic model, at depths 4, 1 and 8
module tb_cla_adder_pipe;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic [31:0] x = '0, y = '0;
    logic in_ready, out_valid, cout, ovf;
    logic [31:0] s;
    logic in_ready1, out_valid1, cout1, ovf1;
    logic [31:0] s1;
    logic in_ready8, out_valid8, cout8, ovf8;
    logic [31:0] s8;
    int tests = 0, fails = 0;
    logic [33:0] q[$];

    always #5 clk = ~clk;

    cla_adder_pipe #(.WIDTH(32), .NUM_STAGES(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf));
    cla_adder_pipe #(.WIDTH(32), .NUM_STAGES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .x(x), .y(y), .cin(cin), .sub(sub),
        .out_valid(out_valid1), .out_ready(1'b1), .s(s1), .cout(cout1), .ovf(ovf1));
    cla_adder_pipe #(.WIDTH(32), .NUM_STAGES(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8), .x(x), .y(y), .cin(cin), .sub(sub),
        .out_valid(out_valid8), .out_ready(1'b1), .s(s8), .cout(cout8), .ovf(ovf8));

    // Returns {ovf, cout, s} from plain two's-complement arithmetic.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb);
        logic [31:0] bb;
        logic [32:0] r;
        logic        v;
        bb = sb ? ~b : b;
        r = {1'b0, a} + {1'b0, bb} + 33'(sb ? 1'b1 : ci);
        v = (a[31] == bb[31]) && (r[31] != a[31]);
        return {v, r};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #3;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (s !== 32'h0) begin fails++; $display("FAIL reset_s got %h want 00000000", s); end
        tests++; if ({cout, ovf} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {cout, ovf}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        repeat (2) @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_idle_valid got %b want 0", out_valid); end
    endtask

    task automatic test_directed;
        logic [31:0] tx [6] = '{32'h5, 32'hFFFF_FFFF, 32'h3, 32'h3, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] ty [6] = '{32'h3, 32'h0, 32'h5, 32'h5, 32'h1, 32'h1};
        logic        tc [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        tb [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [33:0] te [6] = '{{2'b00, 32'h8}, {2'b01, 32'h0}, {2'b00, 32'hFFFF_FFFE},
                                {2'b00, 32'hFFFF_FFFE}, {2'b10, 32'h8000_0000}, {2'b11, 32'h7FFF_FFFF}};
        logic [33:0] m;
        int lat4, lat1, lat8;
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            out_ready = 1'b1;
            x = tx[v]; y = ty[v]; cin = tc[v]; sub = tb[v];
            in_valid = 1'b1;
            m = model(tx[v], ty[v], tc[v], tb[v]);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            x = $urandom; y = $urandom;
            lat4 = -1; lat1 = -1; lat8 = -1;
            for (int e = 0; e < 12; e++) begin
                if (out_valid === 1'b1 && lat4 < 0) begin
                    lat4 = e;
                    tests++; if ({ovf, cout, s} !== te[v]) begin fails++; $display("FAIL dir%0d_ns4 got %h want %h", v, {ovf, cout, s}, te[v]); end
                end
                if (out_valid1 === 1'b1 && lat1 < 0) begin
                    lat1 = e;
                    tests++; if ({ovf1, cout1, s1} !== m) begin fails++; $display("FAIL dir%0d_ns1 got %h want %h", v, {ovf1, cout1, s1}, m); end
                end
                if (out_valid8 === 1'b1 && lat8 < 0) begin
                    lat8 = e;
                    tests++; if ({ovf8, cout8, s8} !== m) begin fails++; $display("FAIL dir%0d_ns8 got %h want %h", v, {ovf8, cout8, s8}, m); end
                end
                @(posedge clk);
                #1;
            end
            tests++; if (lat4 != 3) begin fails++; $display("FAIL dir%0d_lat_ns4 got %0d want 3", v, lat4); end
            tests++; if (lat1 != 0) begin fails++; $display("FAIL dir%0d_lat_ns1 got %0d want 0", v, lat1); end
            tests++; if (lat8 != 7) begin fails++; $display("FAIL dir%0d_lat_ns8 got %0d want 7", v, lat8); end
        end
    endtask

    task automatic test_backpressure;
        int i = 1, got = 0;
        logic stall;
        logic [31:0] held = '0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            stall = (c >= 5 && c < 8);
            out_ready = !stall;
            in_valid = (i <= 8);
            x = stall ? $urandom : 32'(i);
            y = stall ? $urandom : 32'(i);
            sub = stall ? 1'($urandom) : 1'b0;
            cin = stall ? 1'($urandom) : 1'b0;
            #1;
            if (stall) begin
                tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready c%0d got %b want 0", c, in_ready); end
                if (c > 5) begin
                    tests++; if (s !== held) begin fails++; $display("FAIL bp_hold c%0d got %h want %h", c, s, held); end
                end
                held = s;
            end
            if (out_valid === 1'b1 && out_ready) begin
                tests++; if (s !== 32'(2 * (got + 1))) begin fails++; $display("FAIL bp_result%0d got %0d want %0d", got, s, 2 * (got + 1)); end
                got++;
            end
            if (in_valid && in_ready) i++;
        end
        tests++; if (got != 8) begin fails++; $display("FAIL bp_count got %0d want 8", got); end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_dup got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            x = $urandom; y = $urandom;
            cin = 1'($urandom); sub = 1'($urandom);
            if ($urandom_range(0, 7) == 0) x = 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) y = 32'h8000_0000;
            #1;
            tests++; if (in_ready !== (!out_valid || out_ready)) begin fails++; $display("FAIL b2b_ready c%0d got %b", c, in_ready); end
            if (out_valid === 1'b1) begin
                tests++;
                if (q.size() == 0) begin fails++; $display("FAIL b2b_spurious c%0d got %h want none", c, {ovf, cout, s}); end
                else if ({ovf, cout, s} !== q[0]) begin fails++; $display("FAIL b2b_data c%0d got %h want %h", c, {ovf, cout, s}, q[0]); end
                if (out_ready && q.size() > 0) void'(q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(x, y, cin, sub));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (out_valid === 1'b1) begin
                tests++;
                if (q.size() == 0) begin fails++; $display("FAIL drain_spurious got %h want none", {ovf, cout, s}); end
                else begin
                    if ({ovf, cout, s} !== q[0]) begin fails++; $display("FAIL drain_data got %h want %h", {ovf, cout, s}, q[0]); end
                    void'(q.pop_front());
                end
            end
            @(negedge clk);
        end
        tests++; if (q.size() != 0) begin fails++; $display("FAIL drain_lost got %0d pending want 0", q.size()); end
    endtask

    task automatic test_reset_mid;
        sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x = 32'(k + 10); y = 32'(k);
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rst_mid_pre got %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_async got %b want 0", out_valid); end
        tests++; if (s !== 32'h0) begin fails++; $display("FAIL rst_mid_s got %h want 00000000", s); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_ghost c%0d got %b want 0", c, out_valid); end
        end
        @(negedge clk);
        in_valid = 1'b1;
        x = 32'd7; y = 32'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if ({out_valid, s} !== {1'b1, 32'd16}) begin fails++; $display("FAIL rst_mid_after got %b/%0d want 1/16", out_valid, s); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
